// File: rtl/wb_sequencer.sv
// Purpose : register-file write-back sequencer; accepts one request, waits for its source, pulses reg_write.
// Latency : immediate sources write 1 cycle after acceptance, MDR/byte-half MEM_LAT+1, HI on hi_ready+1.
// Backpress: busy=1 while a request is in flight; wb_req seen while busy is dropped, not queued.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   wb_req/wb_src/wb_dst  write-back request, mux source code, destination register
//   hi_ready              HI result of mult/div is valid
//   busy                  request in progress
//   mux_sel, reg_dst      write-back mux select / register address, held until next acceptance
//   reg_write             one-cycle register write enable
//   wb_done               one-cycle pulse when a request retires (written, dropped or aborted)
//   tmo_err               one-cycle pulse when the HI wait is aborted
//
// Optional build macro WB_BACK2BACK_EN: accept a new request during the WRITE cycle.

module wb_sequencer #(
   parameter int MEM_LAT = 2,
   parameter int HI_TMO  = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wb_req,
   input  logic [2:0] wb_src,
   input  logic [4:0] wb_dst,
   input  logic       hi_ready,
   output logic       busy,
   output logic [2:0] mux_sel,
   output logic       reg_write,
   output logic [4:0] reg_dst,
   output logic       wb_done,
   output logic       tmo_err
);

   localparam int MAX_CNT = (MEM_LAT > HI_TMO) ? MEM_LAT : HI_TMO;
   localparam int CW      = $clog2(MAX_CNT) + 1;

`ifdef WB_BACK2BACK_EN
   localparam logic B2B = 1'b1;
`else
   localparam logic B2B = 1'b0;
`endif
   // busy value presented while in WRITE
   localparam logic WR_BUSY = ~B2B;

   typedef enum logic [1:0] {IDLE, MEM_WAIT, HI_WAIT, WRITE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          accept;

   assign accept = wb_req && ((state == IDLE) || (B2B && (state == WRITE)));

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         mux_sel   <= 3'd0;
         reg_write <= 1'b0;
         reg_dst   <= 5'd0;
         wb_done   <= 1'b0;
         tmo_err   <= 1'b0;
         cnt       <= '0;
      end else begin
         // pulse outputs default low; set only on the edge that enters WRITE or retires
         reg_write <= 1'b0;
         wb_done   <= 1'b0;
         tmo_err   <= 1'b0;
         if (accept) begin
            mux_sel <= wb_src;
            reg_dst <= wb_dst;
            if (wb_dst == 5'd0) begin
               // r0 is hard-wired: retire without writing
               state   <= IDLE;
               busy    <= 1'b0;
               wb_done <= 1'b1;
               cnt     <= '0;
            end else begin
               case (wb_src)
                  3'd5, 3'd7: begin
                     state <= MEM_WAIT;
                     busy  <= 1'b1;
                     cnt   <= CW'(MEM_LAT - 1);
                  end
                  3'd3: begin
                     state <= HI_WAIT;
                     busy  <= 1'b1;
                     cnt   <= CW'(HI_TMO - 1);
                  end
                  default: begin
                     state     <= WRITE;
                     busy      <= WR_BUSY;
                     reg_write <= 1'b1;
                     wb_done   <= 1'b1;
                  end
               endcase
            end
         end else begin
            case (state)
               MEM_WAIT: begin
                  if (cnt == '0) begin
                     state     <= WRITE;
                     busy      <= WR_BUSY;
                     reg_write <= 1'b1;
                     wb_done   <= 1'b1;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               HI_WAIT: begin
                  if (hi_ready) begin
                     state     <= WRITE;
                     busy      <= WR_BUSY;
                     reg_write <= 1'b1;
                     wb_done   <= 1'b1;
                  end else if (cnt <= CW'(1)) begin
                     // abort registers on the edge where the counter expires, so
                     // tmo_err appears HI_TMO cycles after acceptance
                     state   <= IDLE;
                     busy    <= 1'b0;
                     tmo_err <= 1'b1;
                     wb_done <= 1'b1;
                     cnt     <= '0;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               WRITE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer: one task per scenario, inline checks.
// Cycle N is the cycle in which a request is driven; outputs are sampled 1 ns after each edge.

module tb_wb_sequencer;

`ifdef WB_BACK2BACK_EN
   localparam logic WR_BUSY = 1'b0;
   localparam int   SECOND  = 2;
`else
   localparam logic WR_BUSY = 1'b1;
   localparam int   SECOND  = 3;
`endif

   logic       clk = 1'b0;
   logic       reset, wb_req, hi_ready;
   logic [2:0] wb_src;
   logic [4:0] wb_dst;

   logic       busy, reg_write, wb_done, tmo_err;
   logic [2:0] mux_sel;
   logic [4:0] reg_dst;
   logic       t_busy, t_reg_write, t_wb_done, t_tmo_err;
   logic [2:0] t_mux_sel;
   logic [4:0] t_reg_dst;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_sequencer #(.MEM_LAT(2), .HI_TMO(64)) dut (
      .clk(clk), .reset(reset), .wb_req(wb_req), .wb_src(wb_src), .wb_dst(wb_dst),
      .hi_ready(hi_ready), .busy(busy), .mux_sel(mux_sel), .reg_write(reg_write),
      .reg_dst(reg_dst), .wb_done(wb_done), .tmo_err(tmo_err)
   );

   wb_sequencer #(.MEM_LAT(2), .HI_TMO(4)) dut_t (
      .clk(clk), .reset(reset), .wb_req(wb_req), .wb_src(wb_src), .wb_dst(wb_dst),
      .hi_ready(hi_ready), .busy(t_busy), .mux_sel(t_mux_sel), .reg_write(t_reg_write),
      .reg_dst(t_reg_dst), .wb_done(t_wb_done), .tmo_err(t_tmo_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      wb_req   = 1'b0;
      wb_src   = 3'd0;
      wb_dst   = 5'd0;
      hi_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({busy, mux_sel, reg_write, reg_dst, wb_done, tmo_err} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs k=%0d got %h exp 000", k,
                     {busy, mux_sel, reg_write, reg_dst, wb_done, tmo_err});
         end
         checks++;
         if ({t_busy, t_mux_sel, t_reg_write, t_reg_dst, t_wb_done, t_tmo_err} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs_t k=%0d got %h exp 000", k,
                     {t_busy, t_mux_sel, t_reg_write, t_reg_dst, t_wb_done, t_tmo_err});
         end
         step();
      end
   endtask

   task automatic test_immediate();
      logic e;
      do_reset();
      wb_req = 1'b1; wb_src = 3'd6; wb_dst = 5'd8;
      for (int k = 1; k <= 3; k++) begin
         step();
         wb_req = 1'b0;
         e = (k == 1);
         checks++;
         if ({reg_write, wb_done} !== {e, e}) begin
            errors++;
            $display("FAIL imm_write k=%0d got %b%b exp %b%b", k, reg_write, wb_done, e, e);
         end
         checks++;
         if (busy !== ((k == 1) ? WR_BUSY : 1'b0)) begin
            errors++;
            $display("FAIL imm_busy k=%0d got %b", k, busy);
         end
         checks++;
         if ({mux_sel, reg_dst} !== {3'd6, 5'd8}) begin
            errors++;
            $display("FAIL imm_sel_dst k=%0d got %0d/%0d exp 6/8", k, mux_sel, reg_dst);
         end
      end
   endtask

   task automatic test_mem();
      logic e, eb;
      do_reset();
      wb_req = 1'b1; wb_src = 3'd5; wb_dst = 5'd3;
      for (int k = 1; k <= 5; k++) begin
         step();
         // a competing request while busy must be ignored
         wb_req = (k == 1);
         wb_src = 3'd6;
         wb_dst = 5'd12;
         e  = (k == 3);
         eb = (k <= 2) ? 1'b1 : ((k == 3) ? WR_BUSY : 1'b0);
         checks++;
         if ({reg_write, wb_done} !== {e, e}) begin
            errors++;
            $display("FAIL mem_write k=%0d got %b%b exp %b%b", k, reg_write, wb_done, e, e);
         end
         checks++;
         if (busy !== eb) begin
            errors++;
            $display("FAIL mem_busy k=%0d got %b exp %b", k, busy, eb);
         end
         checks++;
         if ({mux_sel, reg_dst} !== {3'd5, 5'd3}) begin
            errors++;
            $display("FAIL mem_sel_dst k=%0d got %0d/%0d exp 5/3", k, mux_sel, reg_dst);
         end
      end
      wb_req = 1'b0;
   endtask

   task automatic test_hi_ready();
      logic e, eb;
      do_reset();
      wb_req = 1'b1; wb_src = 3'd3; wb_dst = 5'd9;
      for (int k = 1; k <= 7; k++) begin
         step();
         wb_req   = 1'b0;
         hi_ready = (k >= 5);
         e  = (k == 6);
         eb = (k <= 5) ? 1'b1 : ((k == 6) ? WR_BUSY : 1'b0);
         checks++;
         if ({reg_write, wb_done, tmo_err} !== {e, e, 1'b0}) begin
            errors++;
            $display("FAIL hi_write k=%0d got %b%b%b exp %b%b0", k, reg_write, wb_done, tmo_err, e, e);
         end
         checks++;
         if (busy !== eb) begin
            errors++;
            $display("FAIL hi_busy k=%0d got %b exp %b", k, busy, eb);
         end
         if (k == 6) begin
            checks++;
            if ({mux_sel, reg_dst} !== {3'd3, 5'd9}) begin
               errors++;
               $display("FAIL hi_sel_dst got %0d/%0d exp 3/9", mux_sel, reg_dst);
            end
         end
      end
      hi_ready = 1'b0;
   endtask

   task automatic test_timeout();
      logic e;
      do_reset();
      // hi_ready only in the acceptance cycle: must not be seen
      wb_req = 1'b1; wb_src = 3'd3; wb_dst = 5'd9; hi_ready = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         wb_req   = 1'b0;
         hi_ready = 1'b0;
         e = (k == 4);
         checks++;
         if ({t_tmo_err, t_wb_done, t_reg_write} !== {e, e, 1'b0}) begin
            errors++;
            $display("FAIL tmo_pulse k=%0d got %b%b%b exp %b%b0", k, t_tmo_err, t_wb_done, t_reg_write, e, e);
         end
         checks++;
         if (t_busy !== (k <= 3)) begin
            errors++;
            $display("FAIL tmo_busy k=%0d got %b", k, t_busy);
         end
      end
   endtask

   task automatic test_dst0();
      logic e;
      do_reset();
      wb_req = 1'b1; wb_src = 3'd1; wb_dst = 5'd0;
      for (int k = 1; k <= 3; k++) begin
         step();
         wb_req = 1'b0;
         e = (k == 1);
         checks++;
         if ({wb_done, reg_write, tmo_err} !== {e, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL dst0 k=%0d got %b%b%b exp %b00", k, wb_done, reg_write, tmo_err, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      wb_req = 1'b1; wb_src = 3'd7; wb_dst = 5'd4;
      for (int k = 1; k <= 5; k++) begin
         step();
         wb_req = 1'b0;
         reset  = (k == 1);
         checks++;
         if (reg_write !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_write k=%0d got %b exp 0", k, reg_write);
         end
         if (k == 1) begin
            checks++;
            if ({busy, mux_sel, reg_dst} !== {1'b1, 3'd7, 5'd4}) begin
               errors++;
               $display("FAIL rstmid_accept got %b/%0d/%0d exp 1/7/4", busy, mux_sel, reg_dst);
            end
         end else begin
            checks++;
            if ({busy, mux_sel, reg_write, reg_dst, wb_done, tmo_err} !== 12'd0) begin
               errors++;
               $display("FAIL rstmid_zero k=%0d got %h exp 000", k,
                        {busy, mux_sel, reg_write, reg_dst, wb_done, tmo_err});
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic       e;
      logic [4:0] ed;
      do_reset();
      wb_req = 1'b1; wb_src = 3'd0; wb_dst = 5'd5;
      for (int k = 1; k <= 5; k++) begin
         step();
         wb_req = (k < SECOND);
         wb_dst = 5'd6;
         e  = (k == 1) || (k == SECOND);
         ed = (k >= SECOND) ? 5'd6 : 5'd5;
         checks++;
         if ({reg_write, wb_done} !== {e, e}) begin
            errors++;
            $display("FAIL b2b_write k=%0d got %b%b exp %b%b", k, reg_write, wb_done, e, e);
         end
         checks++;
         if (reg_dst !== ed) begin
            errors++;
            $display("FAIL b2b_dst k=%0d got %0d exp %0d", k, reg_dst, ed);
         end
      end
      wb_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_immediate();
      test_mem();
      test_hi_ready();
      test_timeout();
      test_dst0();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
